controle_rodada: RTL and testbench
==================================

CONTROLE_RODADA -- requirements
Module: controle_rodada

Interface
REQ-001 Parameter TIMEOUT, default 5000, meaning the number of consecutive cycles spent in ESPERA without a jogada before a timeout ending.
REQ-002 Parameter TW, default 13, meaning the timer width in bits; TW SHALL satisfy 2^TW > TIMEOUT.
REQ-003 clock  input  1  rising-edge system clock; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  start/restart request, level-sampled.
REQ-006 jogada  input  1  one-cycle pulse from an external edge detector, meaning a play was entered.
REQ-007 igual  input  1  comparator result, meaning the stored play equals the memory word.
REQ-008 fimE  input  1  fim output of the address counter.
REQ-009 fimL  input  1  fim output of the round-limit counter.
REQ-010 zeraE, contaE  output  1 each  synchronous clear and count enable for the address counter.
REQ-011 zeraL, contaL  output  1 each  synchronous clear and count enable for the round-limit counter.
REQ-012 zeraR, registraR  output  1 each  clear and load strobes for the play register.
REQ-013 pronto, ganhou, perdeu, timeout  output  1 each  game status flags.
REQ-014 db_estado  output  4  current state code, for debug.

Function
REQ-015 The controller SHALL be a Moore FSM; all outputs SHALL decode from the registered state only, and any output not listed for a state SHALL be 0.
REQ-016 State codes SHALL be: INICIAL=0, PREPARA=1, INICIO_RODADA=2, ESPERA=3, REGISTRA=4, COMPARA=5, PROX_JOGADA=6, PROX_RODADA=7, FIM_ACERTO=A, FIM_TIMEOUT=D, FIM_ERRO=E.
REQ-017 INICIAL: all outputs 0; if iniciar=1, next state is PREPARA, else the FSM stays.
REQ-018 PREPARA: zeraE=zeraL=zeraR=1; the FSM SHALL leave after one cycle, unconditionally, to INICIO_RODADA.
REQ-019 INICIO_RODADA: zeraE=1; the FSM SHALL leave after one cycle, unconditionally, to ESPERA.
REQ-020 ESPERA: if jogada=1, next state is REGISTRA; otherwise, if the timer equals TIMEOUT-1, next state is FIM_TIMEOUT; otherwise the FSM stays.
REQ-021 If jogada=1 and the timer equals TIMEOUT-1 in the same cycle, jogada SHALL take priority.
REQ-022 Timer, TW bits: it SHALL increment by 1 each cycle in ESPERA and SHALL be held at 0 in every other state, so each ESPERA visit starts from 0.
REQ-023 The timer SHALL never wrap.
REQ-024 REGISTRA: registraR=1; the FSM SHALL leave after one cycle to COMPARA.
REQ-025 COMPARA: priority order for the next state:
  - igual=0 -> FIM_ERRO;
  - fimE=0 -> PROX_JOGADA;
  - fimL=0 -> PROX_RODADA;
  - otherwise -> FIM_ACERTO.
REQ-026 PROX_JOGADA: contaE=1; the FSM SHALL leave after one cycle to ESPERA.
REQ-027 PROX_RODADA: contaL=1; the FSM SHALL leave after one cycle to INICIO_RODADA.
REQ-028 FIM_ACERTO: pronto=ganhou=1.
REQ-029 FIM_ERRO: pronto=perdeu=1.
REQ-030 FIM_TIMEOUT: pronto=perdeu=timeout=1.
REQ-031 All FIM_* states SHALL hold until iniciar=1, then go to PREPARA.
REQ-032 jogada SHALL be ignored in every state except ESPERA.
REQ-033 iniciar SHALL be ignored in every state except INICIAL and FIM_*.
REQ-034 Latency: an input sampled on clock edge n SHALL change the outputs after edge n, with no combinational input-to-output path.

Reset
REQ-035 reset=1 at a clock edge SHALL force state INICIAL and timer 0, with priority over all other inputs, including mid-game and in FIM_*.
REQ-036 While in reset, all outputs SHALL be 0 and db_estado SHALL be 0 from the first edge with reset=1.

Verification (bench uses TIMEOUT=8, TW=4)
REQ-037 Reset, then iniciar=1 for 1 cycle -> db_estado sequence 0,1,2,3; zeraE=zeraL=zeraR=1 only in state 1; zeraE=1 in state 2.
REQ-038 Round-1 win: in ESPERA, jogada pulse with igual=1, fimE=1, fimL=1 -> states 4,5,A; then pronto=1, ganhou=1, perdeu=0, held until iniciar.
REQ-039 Two-round flow: round 1 with fimE=1, fimL=0 -> 5,7,2,3 with contaL=1 for one cycle; round 2, first play fimE=0 -> 5,6,3 with contaE=1 for one cycle.
REQ-040 Error: jogada with igual=0 -> 4,5,E; pronto=perdeu=1, ganhou=0; iniciar=1 -> state 1.
REQ-041 Timeout: no jogada for 8 cycles in ESPERA -> state D on the 9th edge, timeout=1; a jogada pulse on the 8th cycle (timer=7) -> state 4 instead.
REQ-042 Reset mid-game (in state 4 and in state D) -> state 0 after the next edge; all outputs 0; a stray jogada in state 0 has no effect.

Source files
------------

// File: rtl/controle_rodada.sv
// Round controller for the memory game: a Moore FSM sequencing the address counter,
// the round-limit counter and the play register, with a per-play inactivity timeout.
module controle_rodada #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    estado_t       estado_q;
    estado_t       estado_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // State and timer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= {TW{1'b0}};
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
                else         estado_d = INICIAL;
            end
            PREPARA:       estado_d = INICIO_RODADA;
            INICIO_RODADA: estado_d = ESPERA;
            ESPERA: begin
                // A play arriving on the last timer cycle still counts.
                if (jogada)                  estado_d = REGISTRA;
                else if (timer_q == TIMER_MAX) estado_d = FIM_TIMEOUT;
                else                         estado_d = ESPERA;
            end
            REGISTRA:      estado_d = COMPARA;
            COMPARA: begin
                if (!igual)     estado_d = FIM_ERRO;
                else if (!fimE) estado_d = PROX_JOGADA;
                else if (!fimL) estado_d = PROX_RODADA;
                else            estado_d = FIM_ACERTO;
            end
            PROX_JOGADA:   estado_d = ESPERA;
            PROX_RODADA:   estado_d = INICIO_RODADA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
                if (iniciar) estado_d = PREPARA;
                else         estado_d = estado_q;
            end
            default:       estado_d = INICIAL;
        endcase
    end

    // Timer counts only while remaining in ESPERA, so every visit starts from zero.
    always_comb begin
        timer_d = {TW{1'b0}};
        if (estado_q == ESPERA && estado_d == ESPERA && timer_q != TIMER_MAX) begin
            timer_d = timer_q + TIMER_ONE;
        end else begin
            timer_d = {TW{1'b0}};
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            PREPARA: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            INICIO_RODADA: zeraE     = 1'b1;
            REGISTRA:      registraR = 1'b1;
            PROX_JOGADA:   contaE    = 1'b1;
            PROX_RODADA:   contaL    = 1'b1;
            FIM_ACERTO: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                perdeu  = 1'b1;
                timeout = 1'b1;
            end
            default: begin
                zeraE = 1'b0;
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_rodada.sv
// Scoreboard bench for controle_rodada: each cycle pushes the expected state and
// flags, then pops and compares them one clock later against the DUT outputs.
module tb_controle_rodada;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       fimE = 1'b0;
    logic       fimL = 1'b0;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;

    logic [13:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    controle_rodada #(.TIMEOUT(8), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Flags {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,ganhou,perdeu,timeout}
    function automatic logic [9:0] model_flags(input logic [3:0] st);
        case (st)
            4'h1:    return 10'b1010100000;
            4'h2:    return 10'b1000000000;
            4'h4:    return 10'b0000010000;
            4'h6:    return 10'b0100000000;
            4'h7:    return 10'b0001000000;
            4'hA:    return 10'b0000001100;
            4'hE:    return 10'b0000001010;
            4'hD:    return 10'b0000001011;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [13:0] observe();
        return {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR,
                pronto, ganhou, perdeu, timeout};
    endfunction

    // Step word: {reset,iniciar,jogada,igual,fimE,fimL, expected state after the edge}
    task automatic cyc(input logic [9:0] s);
        {reset, iniciar, jogada, igual, fimE, fimL} = s[9:4];
        sb_q.push_back({s[3:0], model_flags(s[3:0])});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b100000, 4'h0}, {6'b110000, 4'h0}, {6'b101111, 4'h0},
                {6'b000000, 4'h0}, {6'b001111, 4'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL reset step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    task automatic test_start_win();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b010000, 4'h1}, {6'b000000, 4'h2}, {6'b001000, 4'h3},
                {6'b001111, 4'h4}, {6'b010111, 4'h5}, {6'b000111, 4'hA},
                {6'b001000, 4'hA}, {6'b000000, 4'hA}, {6'b010000, 4'h1}};
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL start_win step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    task automatic test_two_rounds();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b000000, 4'h2}, {6'b000000, 4'h3}, {6'b010000, 4'h3},
                {6'b001110, 4'h4}, {6'b000110, 4'h5}, {6'b000110, 4'h7},
                {6'b001000, 4'h2}, {6'b000000, 4'h3}, {6'b001100, 4'h4},
                {6'b000100, 4'h5}, {6'b000100, 4'h6}, {6'b000000, 4'h3},
                {6'b001111, 4'h4}, {6'b000111, 4'h5}, {6'b000111, 4'hA},
                {6'b010000, 4'h1}};
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL two_rounds step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    task automatic test_error();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b000000, 4'h2}, {6'b000000, 4'h3}, {6'b001011, 4'h4},
                {6'b000011, 4'h5}, {6'b000011, 4'hE}, {6'b001000, 4'hE},
                {6'b010000, 4'h1}};
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL error step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b000000, 4'h2}, {6'b000000, 4'h3}};
        for (int k = 0; k < 7; k++) seq.push_back({6'b000000, 4'h3});
        seq.push_back({6'b000000, 4'hD});
        seq.push_back({6'b001000, 4'hD});
        seq.push_back({6'b010000, 4'h1});
        seq.push_back({6'b000000, 4'h2});
        seq.push_back({6'b000000, 4'h3});
        for (int k = 0; k < 7; k++) seq.push_back({6'b000000, 4'h3});
        seq.push_back({6'b001111, 4'h4});
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL timeout step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    task automatic test_reset_midgame();
        logic [9:0]  seq [$];
        logic [13:0] exp_v;
        logic [13:0] got;
        seq = '{{6'b100111, 4'h0}, {6'b001111, 4'h0}, {6'b010000, 4'h1},
                {6'b000000, 4'h2}, {6'b000000, 4'h3}};
        for (int k = 0; k < 7; k++) seq.push_back({6'b000000, 4'h3});
        seq.push_back({6'b000000, 4'hD});
        seq.push_back({6'b110000, 4'h0});
        seq.push_back({6'b001111, 4'h0});
        for (int i = 0; i < seq.size(); i++) begin
            cyc(seq[i]);
            exp_v = sb_q.pop_front();
            got   = observe();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL reset_midgame step %0d: got st=%h fl=%b, want st=%h fl=%b",
                         i, got[13:10], got[9:0], exp_v[13:10], exp_v[9:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_win();
        test_two_rounds();
        test_error();
        test_timeout();
        test_reset_midgame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
